// File: rtl/mc_pulse_scheduler_if.sv
// Command/status bundle between the navigation side, the pulse modulator and one
// scheduler channel. The scheduler takes the slave view.
interface mc_pulse_scheduler_if;
    logic [4:0]  NavMod;
    logic        NavValid;
    logic        NavAck;
    logic [4:0]  OvrMod;
    logic        OvrValid;
    logic [20:0] Pulse;
    logic [4:0]  ModInfo;
    logic [4:0]  State;
    logic        PwmOut;
    logic        FrameStart;
    logic [1:0]  Src;

    modport master (
        output NavMod, NavValid, OvrMod, OvrValid, Pulse,
        input  NavAck, ModInfo, State, PwmOut, FrameStart, Src
    );

    modport slave (
        input  NavMod, NavValid, OvrMod, OvrValid, Pulse,
        output NavAck, ModInfo, State, PwmOut, FrameStart, Src
    );
endinterface

// File: rtl/mc_pulse_scheduler.sv
// Servo frame timebase, command arbiter and ESC PWM driver for one motor channel.
// Define MC_WATCHDOG_EN to force neutral after WDT_FRAMES frames without a nav strobe.
module mc_pulse_scheduler #(
    parameter int CLK_RATE    = 100000000,
    parameter int FRAME_MS    = 20,
    parameter int STATE_COUNT = 24,
    parameter int WDT_FRAMES  = 25
) (
    input logic                 CLK,
    input logic                 RST,
    mc_pulse_scheduler_if.slave bus
);
    localparam longint      FRAME_TICKS = longint'(CLK_RATE) * FRAME_MS / 1000;
    localparam logic [20:0] FRAME_LAST  = 21'(FRAME_TICKS - 1);
    localparam logic [20:0] WIDTH_MIN   = 21'(CLK_RATE / 1000);
    localparam logic [20:0] WIDTH_MAX   = 21'(CLK_RATE / 500);
    localparam logic [20:0] WIDTH_RST   = 21'(longint'(CLK_RATE) * 3 / 2000);
    localparam logic [4:0]  STATE_LAST  = 5'(STATE_COUNT - 1);
    localparam logic [4:0]  NEUTRAL     = 5'b00001;
    localparam logic [1:0]  SRC_NEUTRAL = 2'd0;
    localparam logic [1:0]  SRC_NAV     = 2'd1;
    localparam logic [1:0]  SRC_OVR     = 2'd2;

    logic [20:0] frame_cnt;
    logic [20:0] width;
    logic [20:0] pulse_clamped;
    logic [21:0] pwm_end;
    logic [4:0]  state;
    logic [4:0]  mod_info;
    logic [4:0]  nav_pend;
    logic [4:0]  sel_mod;
    logic [1:0]  src;
    logic [1:0]  sel_src;
    logic        pwm;
    logic        frame_start;
    logic        nav_ack;
    logic        nav_seen;
    logic        wdt_expired;
    logic        wrap;

    assign wrap = (frame_cnt == FRAME_LAST);

`ifdef MC_WATCHDOG_EN
    localparam int                WDT_W   = $clog2(WDT_FRAMES + 1);
    localparam logic [WDT_W-1:0]  WDT_SAT = WDT_W'(WDT_FRAMES);

    logic [WDT_W-1:0] wdt_cnt;

    // A strobe on the saturating edge wins over the increment.
    always_ff @(posedge CLK) begin
        if (RST)
            wdt_cnt <= '0;
        else if (bus.NavValid)
            wdt_cnt <= '0;
        else if (wrap && (wdt_cnt != WDT_SAT))
            wdt_cnt <= wdt_cnt + 1'b1;
    end

    assign wdt_expired = (wdt_cnt == WDT_SAT);
`else
    // No watchdog: expiry can only come from a nonsensical negative limit.
    assign wdt_expired = (WDT_FRAMES < 0);
`endif

    // Until the first nav strobe after reset there is no real command, so report neutral.
    always_comb begin
        sel_mod = nav_pend;
        sel_src = SRC_NAV;
        if (bus.OvrValid) begin
            sel_mod = bus.OvrMod;
            sel_src = SRC_OVR;
        end else if (!nav_seen || wdt_expired) begin
            sel_mod = NEUTRAL;
            sel_src = SRC_NEUTRAL;
        end
        if (sel_mod[1:0] == 2'b11)
            sel_mod[1:0] = 2'b01;
    end

    always_comb begin
        pulse_clamped = bus.Pulse;
        if (bus.Pulse < WIDTH_MIN)
            pulse_clamped = WIDTH_MIN;
        else if (bus.Pulse > WIDTH_MAX)
            pulse_clamped = WIDTH_MAX;
    end

    assign pwm_end = 22'd3 + {1'b0, width};

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt   <= '0;
            state       <= '0;
            frame_start <= 1'b0;
            mod_info    <= NEUTRAL;
            src         <= SRC_NEUTRAL;
            nav_pend    <= NEUTRAL;
            nav_seen    <= 1'b0;
            nav_ack     <= 1'b0;
            width       <= WIDTH_RST;
            pwm         <= 1'b0;
        end else begin
            nav_ack     <= bus.NavValid;
            frame_start <= wrap;
            if (bus.NavValid) begin
                nav_pend <= bus.NavMod;
                nav_seen <= 1'b1;
            end
            if (wrap) begin
                frame_cnt <= '0;
                state     <= (state == STATE_LAST) ? 5'd0 : state + 1'b1;
                mod_info  <= sel_mod;
                src       <= sel_src;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            // Pulse reflects the ModInfo latched at the wrap by FrameCnt==2.
            if (frame_cnt == 21'd2)
                width <= pulse_clamped;
            pwm <= ({1'b0, frame_cnt} >= 22'd3) && ({1'b0, frame_cnt} < pwm_end);
        end
    end

    assign bus.NavAck     = nav_ack;
    assign bus.ModInfo    = mod_info;
    assign bus.State      = state;
    assign bus.PwmOut     = pwm;
    assign bus.FrameStart = frame_start;
    assign bus.Src        = src;
endmodule
